// File: rtl/xlr8_pwm_multi.sv
// Multi-channel PWM XB: NUM_CH channels of WIDTH-bit, double-buffered duty/period, per-channel enables.
// Latency: register writes land on the strobe edge; reads are combinational; pwm_out lags cnt by one clock.
// Backpressure: none; the core bus never stalls, every access completes in its own cycle.
//
// Ports:
//   clk, nrst        core clock, asynchronous active-low reset
//   en16mhz          counter clock enable
//   ramadr/ramre/ramwe/dm_sel/dbus_in   core data-memory bus (low 8 address bits)
//   dbusout/out_en   read data back to the XB slave mux (dbusout is 0 when out_en is 0)
//   pwm_out/pwm_en   per-channel waveform and pin override enable
//
// Register map (offsets from BASE_ADR):
//   +0 CTRL  [7] EN  [6] UPD (write-only, reads 0)  [5] CENTER (optional)  [3:0] CH
//   +1 DUTYL  +2 DUTYH  +3 PERL  +4 PERH  (staging, bits above WIDTH read 0)
//   +5 CHEN   channel enable mask (only the low 8 channels are reachable through this byte)
//
// Optional feature: define XLR8_PWM_CENTER_ALIGNED_EN to add up/down (center-aligned)
// counting selected by CTRL[5]. Without it CTRL[5] reads 0 and the counter is edge-aligned only.

module xlr8_pwm_multi #(
  parameter int         NUM_CH   = 4,
  parameter int         WIDTH    = 16,
  parameter logic [7:0] BASE_ADR = 8'hE0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en16mhz,
  input  logic [7:0]        ramadr,
  input  logic              ramre,
  input  logic              ramwe,
  input  logic              dm_sel,
  input  logic [7:0]        dbus_in,
  output logic [7:0]        dbusout,
  output logic              out_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_en
);

  localparam int CHEN_W = (NUM_CH < 8) ? NUM_CH : 8;

  // Bus decode. Subtracting the base lets one compare cover the whole window.
  logic [7:0] adr_off;
  logic       hit;
  logic       wr;
  logic       rd;
  logic       upd;

  assign adr_off = ramadr - BASE_ADR;
  assign hit     = (adr_off < 8'd6);
  assign wr      = dm_sel & ramwe & hit;
  assign rd      = dm_sel & ramre & hit;
  assign upd     = wr && (adr_off[2:0] == 3'd0) && dbus_in[6];

  // Programmer-visible registers
  logic             ctrl_en;
  logic [3:0]       ctrl_ch;
  logic [WIDTH-1:0] duty_stage;
  logic [WIDTH-1:0] per_stage;
  logic [NUM_CH-1:0] chen;
  logic             center_rd;

`ifdef XLR8_PWM_CENTER_ALIGNED_EN
  logic ctrl_center;
  logic cnt_up;
  logic up_nxt;
  assign center_rd = ctrl_center;
`else
  assign center_rd = 1'b0;
`endif

  // Double buffer: shadow holds committed values, active is what the compare uses.
  logic [WIDTH-1:0] per_shadow;
  logic [WIDTH-1:0] per_active;
  logic [WIDTH-1:0] duty_shadow [NUM_CH];
  logic [WIDTH-1:0] duty_active [NUM_CH];

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             xfer;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ctrl_en    <= 1'b0;
      ctrl_ch    <= '0;
      duty_stage <= '0;
      per_stage  <= '0;
      chen       <= '0;
`ifdef XLR8_PWM_CENTER_ALIGNED_EN
      ctrl_center <= 1'b0;
`endif
    end else if (wr) begin
      case (adr_off[2:0])
        3'd0: begin
          ctrl_en <= dbus_in[7];
          ctrl_ch <= dbus_in[3:0];
`ifdef XLR8_PWM_CENTER_ALIGNED_EN
          ctrl_center <= dbus_in[5];
`endif
        end
        3'd1: duty_stage[7:0]       <= dbus_in;
        3'd2: duty_stage[WIDTH-1:8] <= dbus_in[WIDTH-9:0];
        3'd3: per_stage[7:0]        <= dbus_in;
        3'd4: per_stage[WIDTH-1:8]  <= dbus_in[WIDTH-9:0];
        3'd5: chen[CHEN_W-1:0]      <= dbus_in[CHEN_W-1:0];
        default: ;
      endcase
    end
  end

  // UPD commit: period always; duty only to the channel named in the same write.
  // A CH value beyond NUM_CH matches no channel, so only the period moves.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      per_shadow <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_shadow[i] <= '0;
    end else if (upd) begin
      per_shadow <= per_stage;
      for (int i = 0; i < NUM_CH; i++) begin
        if (dbus_in[3:0] == 4'(i)) duty_shadow[i] <= duty_stage;
      end
    end
  end

  // Counter next-state. xfer marks the edges where shadow -> active; because
  // active samples the pre-edge shadow, an UPD on a wrap edge waits one period.
  always_comb begin
    cnt_nxt = cnt;
    xfer    = 1'b0;
`ifdef XLR8_PWM_CENTER_ALIGNED_EN
    up_nxt  = cnt_up;
`endif
    if (!ctrl_en) begin
      cnt_nxt = '0;
      xfer    = 1'b1;
`ifdef XLR8_PWM_CENTER_ALIGNED_EN
      up_nxt  = 1'b0;
`endif
    end else if (en16mhz) begin
`ifdef XLR8_PWM_CENTER_ALIGNED_EN
      if (ctrl_center) begin
        // cnt_up=0 at cnt=0 is the bottom turnaround (and the start state).
        if (!cnt_up) begin
          if (cnt == '0) begin
            xfer = 1'b1;
            if (per_shadow != '0) begin
              cnt_nxt = WIDTH'(1);
              up_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - WIDTH'(1);
          end
        end else if (cnt >= per_active) begin
          cnt_nxt = cnt - WIDTH'(1);
          up_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        up_nxt = 1'b0;
`endif
        if (cnt == per_active) begin
          cnt_nxt = '0;
          xfer    = 1'b1;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
`ifdef XLR8_PWM_CENTER_ALIGNED_EN
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt        <= '0;
      per_active <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_active[i] <= '0;
`ifdef XLR8_PWM_CENTER_ALIGNED_EN
      cnt_up     <= 1'b0;
`endif
    end else begin
      cnt <= cnt_nxt;
`ifdef XLR8_PWM_CENTER_ALIGNED_EN
      cnt_up <= up_nxt;
`endif
      if (xfer) begin
        per_active <= per_shadow;
        for (int i = 0; i < NUM_CH; i++) duty_active[i] <= duty_shadow[i];
      end
    end
  end

  // Registered compare: duty=0 never high, duty>per always high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pwm_out <= '0;
      pwm_en  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= ctrl_en & chen[i] & (cnt < duty_active[i]);
      end
      pwm_en <= ctrl_en ? chen : '0;
    end
  end

  // Read mux
  always_comb begin
    dbusout = 8'h00;
    if (rd) begin
      case (adr_off[2:0])
        3'd0: dbusout = {ctrl_en, 1'b0, center_rd, 1'b0, ctrl_ch};
        3'd1: dbusout = duty_stage[7:0];
        3'd2: dbusout[WIDTH-9:0] = duty_stage[WIDTH-1:8];
        3'd3: dbusout = per_stage[7:0];
        3'd4: dbusout[WIDTH-9:0] = per_stage[WIDTH-1:8];
        3'd5: dbusout[CHEN_W-1:0] = chen[CHEN_W-1:0];
        default: dbusout = 8'h00;
      endcase
    end
  end

  assign out_en = rd;

endmodule
